// File: rtl/mul_seq_ctrl.sv
// Shift-add multiplier controller: drives one external XLEN-bit adder for
// XLEN iterations to build an unsigned 2*XLEN-bit product.
module mul_seq_ctrl #(
  parameter int XLEN = 32,
  parameter int CNTW = $clog2(XLEN)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [XLEN-1:0]   req_a,
  input  logic [XLEN-1:0]   req_b,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [2*XLEN-1:0] rsp_prod,
  output logic [XLEN-1:0]   add_a,
  output logic [XLEN-1:0]   add_b,
  output logic              add_cin,
  input  logic [XLEN-1:0]   add_sum,
  input  logic              add_cout
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [CNTW-1:0] LAST = CNTW'(XLEN - 1);

  state_t          state;
  logic [CNTW-1:0] cnt;
  logic [XLEN-1:0] mcand;
  logic [XLEN-1:0] p_hi;
  logic [XLEN-1:0] p_lo;
  logic            calc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      mcand     <= '0;
      p_hi      <= '0;
      p_lo      <= '0;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      calc      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            mcand     <= req_a;
            p_lo      <= req_b;
            p_hi      <= '0;
            cnt       <= '0;
            state     <= CALC;
            req_ready <= 1'b0;
            calc      <= 1'b1;
          end
        end
        CALC: begin
          // Adder carry becomes the new top bit; sum LSB shifts into the low word.
          p_hi <= {add_cout, add_sum[XLEN-1:1]};
          p_lo <= {add_sum[0], p_lo[XLEN-1:1]};
          if (cnt == LAST) begin
            cnt       <= '0;
            state     <= DONE;
            calc      <= 1'b0;
            rsp_valid <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          if (rsp_ready) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          req_ready <= 1'b1;
          rsp_valid <= 1'b0;
          calc      <= 1'b0;
        end
      endcase
    end
  end

  assign rsp_prod = {p_hi, p_lo};

  // Adder operands follow p_hi combinationally but are held at zero outside CALC.
  assign add_a   = calc ? p_hi : '0;
  assign add_b   = (calc && p_lo[0]) ? mcand : '0;
  assign add_cin = 1'b0;

endmodule
